// File: rtl/pixel_array_seq.sv
// pixel_array_seq: frame sequencer and readout engine for an N-pixel array
// that shares one DATA bus. Each start runs ERASE, EXPOSE and CONVERT, then
// reads the pixels one at a time and streams their codes out.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, abort      begin a frame (IDLE only) / return to IDLE from any state
//   ERASE, EXPOSE     pixel strobes
//   CONVERT           ramp window; also the output enable for data_out
//   READ              one-hot pixel read select
//   data_out          ramp count (Gray or binary) while CONVERT=1, else 0
//   data_in           DATA bus as seen by this block
//   pix_data/pix_idx  captured pixel code (binary) and its pixel index
//   pix_valid/ready   output handshake
//   busy, frame_done  not-IDLE flag / one-cycle end-of-frame pulse
module pixel_array_seq #(
  parameter int unsigned NUM_PIXELS  = 4,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ERASE_CYC   = 5,
  parameter int unsigned EXPOSE_CYC  = 255,
  parameter int unsigned READ_SETTLE = 1,
  parameter int unsigned GRAY        = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  ERASE,
  output logic                  EXPOSE,
  output logic                  CONVERT,
  output logic [NUM_PIXELS-1:0] READ,
  output logic [DATA_W-1:0]     data_out,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     pix_data,
  output logic [((NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1)-1:0] pix_idx,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned IDX_W = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int unsigned CW_E  = $clog2(ERASE_CYC + 1);
  localparam int unsigned CW_X  = $clog2(EXPOSE_CYC + 1);
  localparam int unsigned CW_C  = DATA_W + 1;
  localparam int unsigned CW_R  = $clog2(READ_SETTLE + 1);
  localparam int unsigned CW_EX = (CW_E > CW_X) ? CW_E : CW_X;
  localparam int unsigned CW_CR = (CW_C > CW_R) ? CW_C : CW_R;
  localparam int unsigned CNT_W = (CW_EX > CW_CR) ? CW_EX : CW_CR;

  localparam logic [CNT_W-1:0] LAST_E   = CNT_W'(ERASE_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_X   = CNT_W'(EXPOSE_CYC - 1);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'({DATA_W{1'b1}});
  localparam logic [CNT_W-1:0] LAST_R   = CNT_W'(READ_SETTLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_GAP, S_RD, S_OUT, S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    erase_q, erase_d;
  logic                    expose_q, expose_d;
  logic                    convert_q, convert_d;
  logic [NUM_PIXELS-1:0]   read_q, read_d;
  logic [DATA_W-1:0]       data_out_q, data_out_d;
  logic [DATA_W-1:0]       pix_data_q, pix_data_d;
  logic [IDX_W-1:0]        pix_idx_q, pix_idx_d;
  logic                    pix_valid_q, pix_valid_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;
  logic [CNT_W-1:0]        cnt_inc;
  logic [DATA_W-1:0]       ramp_bin;

  function automatic logic [DATA_W-1:0] gray2bin(input logic [DATA_W-1:0] g);
    logic [DATA_W-1:0] b;
    b = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    pix_data_d = pix_data_q;
    pix_idx_d  = pix_idx_q;
    cnt_inc    = cnt_q + CNT_W'(1);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ERASE;
          cnt_d   = '0;
        end
      end
      S_ERASE: begin
        if (cnt_q == LAST_E) begin
          state_d = S_EXPOSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_EXPOSE: begin
        if (cnt_q == LAST_X) begin
          state_d = S_CONVERT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_CONVERT: begin
        if (cnt_q == LAST_C) begin
          state_d = S_GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_GAP: begin
        state_d = S_RD;
        cnt_d   = '0;
        idx_d   = '0;
      end
      S_RD: begin
        // DATA is sampled on the last cycle READ is held, after settling.
        if (cnt_q == LAST_R) begin
          state_d    = S_OUT;
          pix_data_d = (GRAY != 0) ? gray2bin(data_in) : data_in;
          pix_idx_d  = idx_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_OUT: begin
        if (pix_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RD;
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = '0;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      cnt_d      = '0;
      idx_d      = '0;
      pix_data_d = '0;
      pix_idx_d  = '0;
    end

    // Outputs are decoded from the next state so that they appear in the
    // same cycle as the state they belong to, while still being registered.
    ramp_bin     = cnt_d[DATA_W-1:0];
    erase_d      = (state_d == S_ERASE);
    expose_d     = (state_d == S_EXPOSE);
    convert_d    = (state_d == S_CONVERT);
    read_d       = (state_d == S_RD) ? (NUM_PIXELS'(1) << idx_d) : '0;
    data_out_d   = '0;
    if (state_d == S_CONVERT) begin
      data_out_d = (GRAY != 0) ? (ramp_bin ^ (ramp_bin >> 1)) : ramp_bin;
    end
    pix_valid_d  = (state_d == S_OUT);
    busy_d       = (state_d != S_IDLE);
    frame_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      erase_q      <= 1'b0;
      expose_q     <= 1'b0;
      convert_q    <= 1'b0;
      read_q       <= '0;
      data_out_q   <= '0;
      pix_data_q   <= '0;
      pix_idx_q    <= '0;
      pix_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      erase_q      <= erase_d;
      expose_q     <= expose_d;
      convert_q    <= convert_d;
      read_q       <= read_d;
      data_out_q   <= data_out_d;
      pix_data_q   <= pix_data_d;
      pix_idx_q    <= pix_idx_d;
      pix_valid_q  <= pix_valid_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ERASE      = erase_q;
  assign EXPOSE     = expose_q;
  assign CONVERT    = convert_q;
  assign READ       = read_q;
  assign data_out   = data_out_q;
  assign pix_data   = pix_data_q;
  assign pix_idx    = pix_idx_q;
  assign pix_valid  = pix_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_array_seq.sv
// Bench for pixel_array_seq: a binary-ramp and a Gray-ramp instance run in
// lockstep from the same stimulus. A pixel model latches each instance's
// DATA at a chosen ramp step; the expected binary code per pixel is queued
// at frame start and compared when the output handshake completes.
module tb_pixel_array_seq;

  localparam int N      = 2;
  localparam int W      = 4;
  localparam int E_CYC  = 2;
  localparam int X_CYC  = 3;
  localparam int SETTLE = 1;
  localparam int C_CYC  = 16;

  logic clk = 1'b0;
  logic reset, start, abort, pix_ready;

  logic         erase_b, expose_b, convert_b, pvalid_b, busy_b, done_b;
  logic [N-1:0] read_b;
  logic [W-1:0] dout_b, din_b, pdata_b;
  logic         pidx_b;
  logic         erase_g, expose_g, convert_g, pvalid_g, busy_g, done_g;
  logic [N-1:0] read_g;
  logic [W-1:0] dout_g, din_g, pdata_g;
  logic         pidx_g;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int tgt[N];
  int conv_k = 0;
  logic [W-1:0] lat_b[N];
  logic [W-1:0] lat_g[N];
  logic mon_en = 1'b0;
  logic conv_prev_b = 1'b0;
  logic conv_prev_g = 1'b0;

  always #5 clk = ~clk;

  pixel_array_seq #(
    .NUM_PIXELS(N), .DATA_W(W), .ERASE_CYC(E_CYC), .EXPOSE_CYC(X_CYC),
    .READ_SETTLE(SETTLE), .GRAY(0)
  ) u_bin (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ERASE(erase_b), .EXPOSE(expose_b), .CONVERT(convert_b), .READ(read_b),
    .data_out(dout_b), .data_in(din_b), .pix_data(pdata_b), .pix_idx(pidx_b),
    .pix_valid(pvalid_b), .pix_ready(pix_ready), .busy(busy_b),
    .frame_done(done_b)
  );

  pixel_array_seq #(
    .NUM_PIXELS(N), .DATA_W(W), .ERASE_CYC(E_CYC), .EXPOSE_CYC(X_CYC),
    .READ_SETTLE(SETTLE), .GRAY(1)
  ) u_gray (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .ERASE(erase_g), .EXPOSE(expose_g), .CONVERT(convert_g), .READ(read_g),
    .data_out(dout_g), .data_in(din_g), .pix_data(pdata_g), .pix_idx(pidx_g),
    .pix_valid(pvalid_g), .pix_ready(pix_ready), .busy(busy_g),
    .frame_done(done_g)
  );

  // Pixel model: each pixel latches the bus when the ramp reaches its target.
  always @(posedge clk) begin
    conv_k <= convert_b ? conv_k + 1 : 0;
    for (int p = 0; p < N; p++) begin
      if (convert_b && conv_k == tgt[p]) begin
        lat_b[p] <= dout_b;
        lat_g[p] <= dout_g;
      end
    end
  end

  assign din_b = read_b[1] ? lat_b[1] : (read_b[0] ? lat_b[0] : '0);
  assign din_g = read_g[1] ? lat_g[1] : (read_g[0] ? lat_g[0] : '0);

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle strobe exclusion and READ/CONVERT adjacency.
  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("mutex_bin", 32'($countones({erase_b, expose_b, convert_b, read_b}) <= 1), 32'd1);
      check_eq("mutex_gray", 32'($countones({erase_g, expose_g, convert_g, read_g}) <= 1), 32'd1);
      check_eq("adj_bin", 32'((conv_prev_b | convert_b) & (|read_b)), 32'd0);
      check_eq("adj_gray", 32'((conv_prev_g | convert_g) & (|read_g)), 32'd0);
    end
    conv_prev_b <= convert_b;
    conv_prev_g <= convert_g;
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Control word: {ERASE, EXPOSE, CONVERT, READ[1], READ[0], busy, pix_valid, frame_done}
  task automatic cmp_ctl(input string tag, input logic [7:0] exp);
    check_eq({tag, "_bin"}, 32'({erase_b, expose_b, convert_b, read_b, busy_b, pvalid_b, done_b}), 32'(exp));
    check_eq({tag, "_gray"}, 32'({erase_g, expose_g, convert_g, read_g, busy_g, pvalid_g, done_g}), 32'(exp));
  endtask

  task automatic cmp_zero(input string tag);
    cmp_ctl(tag, 8'h00);
    check_eq({tag, "_dout_bin"}, 32'(dout_b), 32'd0);
    check_eq({tag, "_dout_gray"}, 32'(dout_g), 32'd0);
    check_eq({tag, "_pdata_bin"}, 32'({pidx_b, pdata_b}), 32'd0);
    check_eq({tag, "_pdata_gray"}, 32'({pidx_g, pdata_g}), 32'd0);
  endtask

  task automatic run_frame(input int t0, input int t1, input int stall,
                           input int abort_at, input bit start_mid,
                           input bit rst_out);
    int n_stall;
    int exp;
    tgt[0] = t0;
    tgt[1] = t1;
    sb.push_back(0 * 256 + t0);
    sb.push_back(1 * 256 + t1);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < E_CYC; i++) begin
      cmp_ctl("erase", 8'b1000_0100);
      step();
    end
    for (int i = 0; i < X_CYC; i++) begin
      cmp_ctl("expose", 8'b0100_0100);
      start = start_mid && (i == 1);
      step();
    end
    start = 1'b0;
    for (int i = 0; i < C_CYC; i++) begin
      cmp_ctl("convert", 8'b0010_0100);
      check_eq("dout_bin", 32'(dout_b), 32'(i));
      check_eq("dout_gray", 32'(dout_g), 32'(i ^ (i >> 1)));
      if (i == abort_at) begin
        abort = 1'b1;
        step();
        abort = 1'b0;
        cmp_zero("abort");
        sb.delete();
        for (int k = 0; k < 3; k++) begin
          step();
          cmp_ctl("abort_idle", 8'h00);
        end
        return;
      end
      step();
    end
    cmp_ctl("gap", 8'b0000_0100);
    check_eq("gap_dout_bin", 32'(dout_b), 32'd0);
    check_eq("gap_dout_gray", 32'(dout_g), 32'd0);
    step();
    for (int p = 0; p < N; p++) begin
      for (int s = 0; s <= SETTLE; s++) begin
        cmp_ctl("read", (p == 0) ? 8'b0000_1100 : 8'b0001_0100);
        step();
      end
      n_stall = (p == 0) ? stall : 0;
      for (int k = 0; k <= n_stall; k++) begin
        cmp_ctl("out", 8'b0000_0110);
        check_eq("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        exp = (sb.size() > 0) ? sb[0] : -1;
        check_eq("pix_bin", 32'({pidx_b, pdata_b}), 32'(((exp / 256) << W) | (exp % 256)));
        check_eq("pix_gray", 32'({pidx_g, pdata_g}), 32'(((exp / 256) << W) | (exp % 256)));
        if (rst_out) begin
          reset = 1'b1;
          step();
          reset = 1'b0;
          cmp_zero("reset_out");
          sb.delete();
          step();
          cmp_ctl("reset_idle", 8'h00);
          return;
        end
        pix_ready = (k == n_stall);
        step();
        if (k == n_stall && sb.size() > 0) void'(sb.pop_front());
      end
      pix_ready = 1'b1;
    end
    cmp_ctl("done", 8'b0000_0101);
    step();
    cmp_ctl("idle", 8'h00);
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    pix_ready = 1'b1;
    tgt[0] = 0;
    tgt[1] = 0;
    step();
    step();
    cmp_zero("reset");
    reset = 1'b0;
    mon_en = 1'b1;
    step();
    cmp_zero("idle0");

    run_frame(5, 9, 0, -1, 1'b0, 1'b0);    // basic frame, ready high
    run_frame(11, 15, 0, -1, 1'b0, 1'b0);  // Gray 1110 -> 11, top of ramp
    run_frame(0, 15, 0, -1, 1'b0, 1'b0);   // ramp end points
    run_frame(3, 12, 10, -1, 1'b0, 1'b0);  // 10-cycle backpressure on pixel 0
    run_frame(4, 4, 0, 7, 1'b0, 1'b0);     // abort in 8th CONVERT cycle
    run_frame(6, 1, 0, -1, 1'b0, 1'b0);    // full frame after abort
    run_frame(2, 13, 0, -1, 1'b1, 1'b0);   // start pulsed during EXPOSE

    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmp_ctl("start_abort_idle", 8'h00);
      step();
    end

    run_frame(7, 8, 0, -1, 1'b0, 1'b1);    // reset while pix_valid is high
    run_frame(1, 14, 0, -1, 1'b0, 1'b0);   // recovery after reset

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
